// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the RAM port arbiter
package ram_arb_pkg;

   localparam int RAM_ADDR_W = 25;
   localparam int RAM_DATA_W = 16;

   localparam logic [1:0] REQ_SD     = 2'd0;
   localparam logic [1:0] REQ_VID    = 2'd1;
   localparam logic [1:0] REQ_CPU    = 2'd2;
   localparam logic [1:0] GRANT_NONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } arb_state_e;

   // One-hot strobe for a requester index; GRANT_NONE maps to no strobe.
   function automatic logic [2:0] req_onehot(input logic [1:0] idx);
      logic [2:0] oh;
      oh = 3'b000;
      case (idx)
         REQ_SD:  oh = 3'b001;
         REQ_VID: oh = 3'b010;
         REQ_CPU: oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/ram_arb_select.sv
// rtl/ram_arb_select.sv - combinational winner selection among the three requesters
module ram_arb_select
   import ram_arb_pkg::*;
(
   input  logic [2:0] req_i,
   input  logic       boot_done_i,
   input  logic       rr_prefer_vid_i,
   output logic [1:0] winner_o,
   output logic       valid_o
);

   logic [2:0] elig;

   // Loader always wins; video/CPU only compete after boot, tie broken by the preference bit.
   always_comb begin
      elig     = {req_i[2] & boot_done_i, req_i[1] & boot_done_i, req_i[0]};
      valid_o  = |elig;
      winner_o = GRANT_NONE;
      if (elig[0]) begin
         winner_o = REQ_SD;
      end else if (elig[1] && elig[2]) begin
         winner_o = rr_prefer_vid_i ? REQ_VID : REQ_CPU;
      end else if (elig[1]) begin
         winner_o = REQ_VID;
      end else if (elig[2]) begin
         winner_o = REQ_CPU;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - three-way arbiter in front of the SDRAM controller
// Optional: RAM_ARB_ROUND_ROBIN_EN makes requesters 1 and 2 alternate on ties.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W     = RAM_ADDR_W,
   parameter int DATA_W     = RAM_DATA_W,
   parameter int RD_TIMEOUT = 255
)(
   input  logic                  clk50,
   input  logic                  reset_n,
   input  logic                  boot_done,
   input  logic [2:0]            req_i,
   input  logic [2:0]            we_i,
   input  logic [3*ADDR_W-1:0]   addr_i,
   input  logic [3*DATA_W-1:0]   wdata_i,
   output logic [2:0]            op_begun_o,
   output logic [2:0]            rvalid_o,
   output logic [DATA_W-1:0]     rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   input  logic                  mem_ack_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_W-1:0]     mem_rdata_i,
   output logic [1:0]            grant_o,
   output logic                  timeout_err_o
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RD_TIMEOUT);

   arb_state_e          state_q, state_d;
   logic [1:0]          owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic                tout_q, tout_d;

   logic [1:0]          sel_win;
   logic                sel_valid;
   logic                rr_prefer;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic rr_q, rr_d;
   assign rr_prefer = rr_q;
`else
   assign rr_prefer = 1'b1;
`endif

   ram_arb_select u_select (
      .req_i           (req_i),
      .boot_done_i     (boot_done),
      .rr_prefer_vid_i (rr_prefer),
      .winner_o        (sel_win),
      .valid_o         (sel_valid)
   );

   // Pick the winning requester's we/addr/wdata out of the flattened buses.
   always_comb begin
      lat_we    = we_i[0];
      lat_addr  = addr_i[0 +: ADDR_W];
      lat_wdata = wdata_i[0 +: DATA_W];
      case (sel_win)
         REQ_VID: begin
            lat_we    = we_i[1];
            lat_addr  = addr_i[ADDR_W +: ADDR_W];
            lat_wdata = wdata_i[DATA_W +: DATA_W];
         end
         REQ_CPU: begin
            lat_we    = we_i[2];
            lat_addr  = addr_i[2*ADDR_W +: ADDR_W];
            lat_wdata = wdata_i[2*DATA_W +: DATA_W];
         end
         default: ;
      endcase
   end

   assign cnt_inc = cnt_q + 1'b1;

   // Next-state and output decode; memory side only sees the latched copy of the request.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      tout_d      = tout_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      rr_d        = rr_q;
`endif
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      op_begun_o  = 3'b000;
      rvalid_o    = 3'b000;
      rdata_o     = '0;
      grant_o     = (state_q == IDLE) ? GRANT_NONE : owner_q;

      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               owner_d = sel_win;
               we_d    = lat_we;
               addr_d  = lat_addr;
               wdata_d = lat_wdata;
               cnt_d   = '0;
               state_d = ISSUE;
`ifdef RAM_ARB_ROUND_ROBIN_EN
               if (sel_win == REQ_VID) rr_d = 1'b0;
               if (sel_win == REQ_CPU) rr_d = 1'b1;
`endif
            end
         end
         ISSUE: begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            if (mem_ack_i) begin
               op_begun_o = req_onehot(owner_q);
               if (we_q) begin
                  state_d = IDLE;
               end else if (mem_rvalid_i) begin
                  rvalid_o = req_onehot(owner_q);
                  rdata_o  = mem_rdata_i;
                  state_d  = IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = WAIT_RD;
               end
            end
         end
         WAIT_RD: begin
            if (mem_rvalid_i) begin
               rvalid_o = req_onehot(owner_q);
               rdata_o  = mem_rdata_i;
               state_d  = IDLE;
            end else if (cnt_inc == CNT_LIMIT) begin
               tout_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign timeout_err_o = tout_q;

   // State register with synchronous active-low reset; reset abandons any in-flight read.
   always_ff @(posedge clk50) begin
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= GRANT_NONE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         tout_q  <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         rr_q    <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         tout_q  <= tout_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         rr_q    <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

   localparam int AW  = 25;
   localparam int DW  = 16;
   localparam int TMO = 255;

   logic clk50 = 1'b0;
   always #10 clk50 = ~clk50;

   logic              reset_n, boot_done;
   logic [2:0]        req_i, we_i;
   logic [AW-1:0]     a [3];
   logic [DW-1:0]     wd [3];
   logic [3*AW-1:0]   addr_i;
   logic [3*DW-1:0]   wdata_i;
   logic [2:0]        op_begun_o, rvalid_o;
   logic [DW-1:0]     rdata_o;
   logic              mem_req_o, mem_we_o;
   logic [AW-1:0]     mem_addr_o;
   logic [DW-1:0]     mem_wdata_o;
   logic              mem_ack_i, mem_rvalid_i;
   logic [DW-1:0]     mem_rdata_i;
   logic [1:0]        grant_o;
   logic              timeout_err_o;

   assign addr_i  = {a[2], a[1], a[0]};
   assign wdata_i = {wd[2], wd[1], wd[0]};

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TMO)) dut (
      .clk50         (clk50),
      .reset_n       (reset_n),
      .boot_done     (boot_done),
      .req_i         (req_i),
      .we_i          (we_i),
      .addr_i        (addr_i),
      .wdata_i       (wdata_i),
      .op_begun_o    (op_begun_o),
      .rvalid_o      (rvalid_o),
      .rdata_o       (rdata_o),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_ack_i     (mem_ack_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .grant_o       (grant_o),
      .timeout_err_o (timeout_err_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Transaction-level model: the one operation in flight, if any.
   bit            m_busy, m_acc, m_we, m_tout;
   int            m_owner, m_wait, m_pref;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;

   logic [2:0]    s_op, s_rv;
   logic [1:0]    s_grant;
   logic          s_req, s_tout;
   logic [AW-1:0] s_maddr;
   logic [DW-1:0] s_mwd, s_rdata;

   int order[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      logic [2:0] e_op, e_rv;
      logic       e_req;
      logic [1:0] e_grant;
      e_op = 3'b000; e_rv = 3'b000; e_req = 1'b0; e_grant = 2'd3;
      if (m_busy) begin
         e_grant = 2'(m_owner);
         if (!m_acc) begin
            e_req = 1'b1;
            if (mem_ack_i) begin
               e_op = 3'b001 << m_owner;
               if (!m_we && mem_rvalid_i) e_rv = 3'b001 << m_owner;
            end
         end else if (mem_rvalid_i) begin
            e_rv = 3'b001 << m_owner;
         end
      end
      s_op = op_begun_o; s_rv = rvalid_o; s_grant = grant_o; s_req = mem_req_o;
      s_tout = timeout_err_o; s_maddr = mem_addr_o; s_mwd = mem_wdata_o; s_rdata = rdata_o;
      chk("grant", 32'(s_grant), 32'(e_grant));
      chk("mem_req", 32'(s_req), 32'(e_req));
      chk("op_begun", 32'(s_op), 32'(e_op));
      chk("rvalid", 32'(s_rv), 32'(e_rv));
      chk("timeout_err", 32'(s_tout), 32'(m_tout));
      if (e_req) begin
         chk("mem_we", 32'(mem_we_o), 32'(m_we));
         chk("mem_addr", 32'(s_maddr), 32'(m_addr));
         chk("mem_wdata", 32'(s_mwd), 32'(m_wdata));
      end
      if (e_rv != 3'b000) chk("rdata", 32'(s_rdata), 32'(mem_rdata_i));
   endtask

   task automatic model_update();
      int w;
      w = -1;
      if (!reset_n) begin
         m_busy = 0; m_acc = 0; m_tout = 0; m_pref = 1;
         return;
      end
      if (!m_busy) begin
         if (req_i[0]) w = 0;
         else if (boot_done) begin
            if (req_i[1] && req_i[2]) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
               w = m_pref;
`else
               w = 1;
`endif
            end else if (req_i[1]) w = 1;
            else if (req_i[2]) w = 2;
         end
         if (w >= 0) begin
            m_busy = 1; m_acc = 0; m_owner = w;
            m_we = we_i[w]; m_addr = a[w]; m_wdata = wd[w];
            if (w != 0) m_pref = 3 - w;
         end
      end else if (!m_acc) begin
         if (mem_ack_i) begin
            if (m_we || mem_rvalid_i) m_busy = 0;
            else begin m_acc = 1; m_wait = 0; end
         end
      end else begin
         if (mem_rvalid_i) m_busy = 0;
         else begin
            m_wait++;
            if (m_wait == TMO) begin m_tout = 1; m_busy = 0; end
         end
      end
   endtask

   // One clock: check outputs mid-cycle, advance the model, then return just after the edge.
   task automatic step();
      @(negedge clk50);
      compare();
      model_update();
      @(posedge clk50);
      #1;
   endtask

   function automatic int idx_of(input logic [2:0] oh);
      return oh[0] ? 0 : (oh[1] ? 1 : 2);
   endfunction

   initial begin
      int n;
      bit got_rv;
      int exp_rr [4];
      reset_n = 0; boot_done = 0; req_i = 0; we_i = 0;
      mem_ack_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
      for (int i = 0; i < 3; i++) begin a[i] = '0; wd[i] = '0; end
      m_busy = 0; m_acc = 0; m_tout = 0; m_pref = 1; m_owner = 0; m_wait = 0;
      m_we = 0; m_addr = '0; m_wdata = '0;
      @(posedge clk50); #1;
      step(); step();
      chk("rst_grant", 32'(s_grant), 32'd3);
      chk("rst_mem_req", 32'(s_req), 32'd0);
      chk("rst_timeout", 32'(s_tout), 32'd0);

      // SD loader write before boot
      reset_n = 1;
      req_i = 3'b001; we_i = 3'b001; a[0] = 25'h000010; wd[0] = 16'hBEEF;
      step();
      step();
      chk("sd_mem_req", 32'(s_req), 32'd1);
      chk("sd_addr", 32'(s_maddr), 32'h10);
      chk("sd_wdata", 32'(s_mwd), 32'hBEEF);
      step();
      mem_ack_i = 1;
      step();
      chk("sd_op_begun", 32'(s_op), 32'b001);
      req_i = 0; mem_ack_i = 0;
      step();
      chk("sd_op_pulse", 32'(s_op), 32'b000);
      chk("sd_idle", 32'(s_grant), 32'd3);

      // video/CPU locked out until boot_done
      req_i = 3'b110; we_i = 3'b110; a[1] = 25'h0000AA; wd[1] = 16'h5555;
      a[2] = 25'h0000BB; wd[2] = 16'h6666;
      for (int i = 0; i < 20; i++) step();
      chk("lock_grant", 32'(s_grant), 32'd3);
      chk("lock_mem_req", 32'(s_req), 32'd0);
      boot_done = 1;
      step();
      step();
      chk("boot_grant", 32'(s_grant), 32'd1);
      mem_ack_i = 1;
      step();
      chk("boot_op_begun", 32'(s_op), 32'b010);
      req_i = 0; mem_ack_i = 0;
      step();

      // requester 2 read with delayed data
      req_i = 3'b100; we_i = 3'b000; a[2] = 25'h1ABCDE;
      step();
      mem_ack_i = 1;
      step();
      chk("rd_op_begun", 32'(s_op), 32'b100);
      chk("rd_addr", 32'(s_maddr), 32'h1ABCDE);
      req_i = 0; mem_ack_i = 0;
      repeat (4) step();
      mem_rvalid_i = 1; mem_rdata_i = 16'h1234;
      step();
      chk("rd_rvalid", 32'(s_rv), 32'b100);
      chk("rd_rdata", 32'(s_rdata), 32'h1234);
      mem_rvalid_i = 0;
      step();
      chk("rd_rvalid_pulse", 32'(s_rv), 32'b000);

      // all three requesting: fixed order
      req_i = 3'b111; we_i = 3'b111; mem_ack_i = 1;
      order.delete();
      for (int i = 0; i < 20 && req_i != 0; i++) begin
         step();
         if (s_op != 0) begin order.push_back(idx_of(s_op)); req_i = req_i & ~s_op; end
      end
      chk("prio_count", 32'(order.size()), 32'd3);
      if (order.size() == 3) begin
         chk("prio_0", 32'(order[0]), 32'd0);
         chk("prio_1", 32'(order[1]), 32'd1);
         chk("prio_2", 32'(order[2]), 32'd2);
      end

      // requesters 1 and 2 continuously requesting
      req_i = 3'b110; we_i = 3'b110;
      order.delete();
      for (int i = 0; i < 30 && order.size() < 4; i++) begin
         step();
         if (s_op != 0) order.push_back(idx_of(s_op));
      end
`ifdef RAM_ARB_ROUND_ROBIN_EN
      exp_rr = '{1, 2, 1, 2};
`else
      exp_rr = '{1, 1, 1, 1};
`endif
      chk("cont_count", 32'(order.size()), 32'd4);
      for (int i = 0; i < 4 && i < order.size(); i++) chk("cont_order", 32'(order[i]), 32'(exp_rr[i]));
      req_i = 0; mem_ack_i = 0;
      step();

      // read timeout
      req_i = 3'b010; we_i = 3'b000; a[1] = 25'h0F0F0F;
      step();
      mem_ack_i = 1;
      step();
      chk("tmo_op_begun", 32'(s_op), 32'b010);
      req_i = 0; mem_ack_i = 0;
      n = 0; got_rv = 0;
      for (int i = 0; i < 400; i++) begin
         step();
         n++;
         if (s_rv != 0) got_rv = 1;
         if (s_tout) break;
      end
      chk("tmo_cycles", 32'(n), 32'(TMO + 1));
      chk("tmo_no_rvalid", 32'(got_rv), 32'd0);
      chk("tmo_idle", 32'(s_grant), 32'd3);
      req_i = 3'b001; we_i = 3'b001; a[0] = 25'h000123; wd[0] = 16'hCAFE;
      step();
      mem_ack_i = 1;
      step();
      chk("tmo_next_served", 32'(s_op), 32'b001);
      req_i = 0; mem_ack_i = 0;
      step();

      // reset during WAIT_RD
      req_i = 3'b100; we_i = 3'b000;
      step();
      mem_ack_i = 1;
      step();
      req_i = 0; mem_ack_i = 0;
      step(); step();
      reset_n = 0;
      step();
      reset_n = 1;
      step();
      chk("rstw_mem_req", 32'(s_req), 32'd0);
      chk("rstw_grant", 32'(s_grant), 32'd3);
      chk("rstw_timeout", 32'(s_tout), 32'd0);

      // randomized traffic
      boot_done = 1;
      for (int c = 0; c < 4000; c++) begin
         if (!reset_n) reset_n = 1;
         else if ($urandom_range(699) == 0) reset_n = 0;
         if ($urandom_range(149) == 0) boot_done = ~boot_done;
         for (int r = 0; r < 3; r++) begin
            if (req_i[r] && s_op[r]) req_i[r] = 1'b0;
            else if (!req_i[r] && $urandom_range(2) == 0) begin
               req_i[r] = 1'b1;
               we_i[r]  = 1'($urandom_range(1));
               a[r]     = AW'($urandom);
               wd[r]    = DW'($urandom);
            end else if (req_i[r] && m_busy && !m_acc && m_owner == r && $urandom_range(15) == 0)
               req_i[r] = 1'b0;
         end
         mem_ack_i    = (m_busy && !m_acc) ? ($urandom_range(2) == 0) : 1'b0;
         mem_rvalid_i = (m_busy && !m_we) ? ($urandom_range(3) == 0) : 1'b0;
         mem_rdata_i  = DW'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single 32Mx16 RAM port between three requesters:
  - Requester 0: the SD-card block loader, which writes words.
  - Requester 1: the video/sprite fetch.
  - Requester 2: the CPU/game logic.
- Requesters 1 and 2 are locked out until boot_done is asserted, so the loader owns the RAM during initialization.
- Sits between the requesters and the SDRAM controller.
- Requester-side signalling matches the loader's handshake: hold we/req until a one-cycle op_begun pulse.

Parameters:
ADDR_W, 25, RAM word-address width
DATA_W, 16, RAM data width
RD_TIMEOUT, 255, max cycles waiting for mem_rvalid_i after a read is accepted

Ports:
clk50  in  1  system clock, 50 MHz
reset_n  in  1  synchronous, active-low reset
boot_done  in  1  high once the SD loader reports init done; enables requesters 1 and 2
req_i  in  3  per-requester request; bit n = requester n
we_i  in  3  per-requester write enable; meaningful only while req_i[n]=1
addr_i  in  3*ADDR_W  flattened addresses; requester n uses bits [n*ADDR_W +: ADDR_W]
wdata_i  in  3*DATA_W  flattened write data, same packing
op_begun_o  out  3  one-cycle accept pulse back to the granted requester
rvalid_o  out  3  one-cycle read-data-valid pulse to the read owner
rdata_o  out  DATA_W  read data, valid while rvalid_o is nonzero
mem_req_o  out  1  request to the SDRAM controller
mem_we_o  out  1  write enable to the controller
mem_addr_o  out  ADDR_W  address to the controller
mem_wdata_o  out  DATA_W  write data to the controller
mem_ack_i  in  1  controller accepted the current operation
mem_rvalid_i  in  1  controller read data valid
mem_rdata_i  in  DATA_W  controller read data
grant_o  out  2  index of the current owner; 3 = none
timeout_err_o  out  1  sticky read-timeout flag

Behaviour:
- Reset (reset_n=0 at clk50 edge):
  - state=IDLE, grant_o=3, timeout counter=0, RR pointer=1.
  - All other outputs 0.
- Eligibility:
  - Requester 0 is always eligible.
  - Requesters 1 and 2 are eligible only when boot_done=1.
- Winner selection: fixed priority 0 > 1 > 2.
- IDLE:
  - If any eligible req_i: latch winner index, we, addr and wdata into registers; go to ISSUE next cycle.
  - Otherwise remain in IDLE with grant_o=3.
- ISSUE:
  - Drive mem_req_o=1 and mem_we_o/mem_addr_o/mem_wdata_o from the latched registers.
  - When mem_ack_i=1: op_begun_o[owner]=1 in the same cycle (combinational on state and mem_ack_i).
  - After ack, next state is IDLE if write, WAIT_RD if read.
- WAIT_RD:
  - mem_req_o=0; the counter increments each cycle.
  - When mem_rvalid_i=1: rvalid_o[owner]=1 and rdata_o=mem_rdata_i that cycle; go to IDLE.
  - If the counter reaches RD_TIMEOUT first: set timeout_err_o and go to IDLE. No rvalid_o is issued.
- Latency:
  - Request to mem_req_o: 1 cycle.
  - Every grant passes through IDLE for at least 1 cycle, so a requester dropping req after op_begun is never re-granted.
- Requester rule: req/we/addr/wdata stay stable until op_begun. The arbiter uses latched copies, so a requester dropping early does not corrupt mem_* signals.
- Simultaneous events:
  - mem_ack_i and mem_rvalid_i in the same ISSUE cycle: the read completes immediately (rvalid_o pulses, go to IDLE).
  - req deasserted while in ISSUE: the operation still completes.
- boot_done falling while requester 1 or 2 owns the port: the current operation completes, and that requester is then ineligible.
- reset_n low mid-operation: immediate return to IDLE and mem_req_o=0 at the next edge. Any in-flight read data is discarded.
- timeout_err_o is cleared only by reset.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Requesters 1 and 2 share in round-robin order via a 1-bit pointer; requester 0 keeps absolute priority.
  - The pointer toggles to the other requester after each grant to requester 1 or 2.
- Undefined: fixed 0 > 1 > 2 priority; no pointer register.

Decomposition:
- Package ram_arb_pkg:
  - State enum {IDLE, ISSUE, WAIT_RD}.
  - Requester index constants REQ_SD=0, REQ_VID=1, REQ_CPU=2, GRANT_NONE=3.
  - ADDR_W and DATA_W defaults.
- Sub-module ram_arb_select: combinational winner selection from req_i, boot_done and the RR pointer; outputs winner index and a valid flag.

Test Plan:
- SD write, boot_done=0, req_i=001, we=1, addr=0x000010, wdata=0xBEEF, mem_ack after 2 cycles -> mem_addr_o=0x000010, mem_wdata_o=0xBEEF, op_begun_o=001 for 1 cycle, then IDLE.
- boot_done=0, req_i=110 -> mem_req_o stays 0 and grant_o=3 indefinitely; set boot_done=1 -> requester 1 is granted.
- Requester 2 read of addr 0x1ABCDE, mem_rvalid after 5 cycles with 0x1234 -> rvalid_o=100 and rdata_o=0x1234 for 1 cycle.
- req_i=111 with boot_done=1 -> grant order 0, 1, 2 with fixed priority; with RAM_ARB_ROUND_ROBIN_EN and 1/2 continuously requesting -> 1, 2, 1, 2.
- Read with mem_rvalid never asserted -> timeout_err_o=1 after 255 cycles, no rvalid_o, state IDLE, next request served.
- reset_n=0 during WAIT_RD -> next cycle mem_req_o=0, grant_o=3, timeout_err_o=0.
